// File: rtl/t5_deco.sv
// t5_deco: decode stage of the 4-hart barrel-threaded RV32I pipeline.
// Captures the fetched word plus PC/hart tag and produces registered decode
// fields for execute. Bubbles are inserted during post-reset warm-up, on a
// missing fetch acknowledge and for hart slots squashed by execute.
// Build option: define T5_RVE_EN for RV32E mode (register addresses >= 16
// are reported as illegal).
//
// state  | meaning
// S_WARM | pipeline warm-up, every advanced slot is a bubble
// S_RUN  | normal decode, dval follows ack and kill mask
module t5_deco #(
    parameter int XLEN = 32,
    parameter int WARM = 4
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [XLEN-1:0] iwb_dat,
    input  logic            iwb_ack,
    input  logic [XLEN-1:0] fpc,
    input  logic            xkill,
    input  logic [1:0]      xkhart,
    output logic [XLEN-3:0] dpc,
    output logic [1:0]      dhrt,
    output logic            dval,
    output logic            dill,
    output logic [4:0]      drs1,
    output logic [4:0]      drs2,
    output logic [4:0]      drd,
    output logic [4:0]      dopc,
    output logic [2:0]      dfn3,
    output logic            dfn7,
    output logic [XLEN-1:0] dimm
);

    localparam int CW = (WARM < 1) ? 1 : $clog2(WARM + 1);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_MISC   = 5'b00011;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic {S_WARM, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [3:0]      r_kill;
    logic [3:0]      w_kill_set;
    logic [3:0]      w_kill_clr;

    logic [XLEN-3:0] r_dpc;
    logic [1:0]      r_dhrt;
    logic            r_dval;
    logic            r_dill;
    logic [4:0]      r_drs1;
    logic [4:0]      r_drs2;
    logic [4:0]      r_drd;
    logic [4:0]      r_dopc;
    logic [2:0]      r_dfn3;
    logic            r_dfn7;
    logic [XLEN-1:0] r_dimm;

    logic [4:0]      w_opc;
    logic [1:0]      w_hart;
    logic            w_dval;
    logic            w_ill;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_rve_bad;

    assign w_opc  = iwb_dat[6:2];
    assign w_hart = fpc[1:0];

    // Warm-up state and counter registers.
    always_ff @(posedge sclk) begin
        if (srst) begin
            r_state <= S_WARM;
            r_cnt   <= CW'(WARM);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Warm-up next state: count advanced slots down, leave WARM at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WARM: begin
                if (sena) begin
                    if (r_cnt <= CW'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_WARM;
            end
        endcase
    end

    // Kill mask update: a fresh set beats the clear from a consumed slot.
    always_comb begin
        w_kill_set = xkill ? (4'b0001 << xkhart) : 4'b0000;
        w_kill_clr = sena ? (4'b0001 << w_hart) : 4'b0000;
    end

    // Kill mask register.
    always_ff @(posedge sclk) begin
        if (srst) begin
            r_kill <= 4'b0000;
        end else begin
            r_kill <= (r_kill & ~w_kill_clr) | w_kill_set;
        end
    end

    assign w_dval = (r_state == S_RUN) & iwb_ack & ~r_kill[w_hart];

    // Combinational field decode: rd suppression, immediate and legality.
    always_comb begin
        w_rd      = iwb_dat[11:7];
        w_imm     = '0;
        w_ill     = 1'b0;
        w_rve_bad = 1'b0;

        if ((w_opc == OP_STORE) || (w_opc == OP_BRANCH) || (w_opc == OP_MISC)) begin
            w_rd = 5'd0;
        end

        case (w_opc)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM:
                w_imm = {{20{iwb_dat[31]}}, iwb_dat[31:20]};
            OP_STORE:
                w_imm = {{20{iwb_dat[31]}}, iwb_dat[31:25], iwb_dat[11:7]};
            OP_BRANCH:
                w_imm = {{19{iwb_dat[31]}}, iwb_dat[31], iwb_dat[7],
                         iwb_dat[30:25], iwb_dat[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {iwb_dat[31:12], 12'h000};
            OP_JAL:
                w_imm = {{11{iwb_dat[31]}}, iwb_dat[31], iwb_dat[19:12],
                         iwb_dat[20], iwb_dat[30:21], 1'b0};
            default:
                w_imm = '0;
        endcase

        case (w_opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
            OP_OPIMM, OP_MISC, OP_SYSTEM:
                w_ill = 1'b0;
            OP_OP:
                w_ill = (iwb_dat[31:25] != 7'h00) && (iwb_dat[31:25] != 7'h20);
            OP_BRANCH:
                w_ill = (iwb_dat[14:12] == 3'd2) || (iwb_dat[14:12] == 3'd3);
            default:
                w_ill = 1'b1;
        endcase

`ifdef T5_RVE_EN
        // Only registers the format actually reads or writes are checked.
        case (w_opc)
            OP_OP:
                w_rve_bad = iwb_dat[19] | iwb_dat[24] | iwb_dat[11];
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM:
                w_rve_bad = iwb_dat[19] | iwb_dat[11];
            OP_STORE, OP_BRANCH:
                w_rve_bad = iwb_dat[19] | iwb_dat[24];
            OP_LUI, OP_AUIPC, OP_JAL:
                w_rve_bad = iwb_dat[11];
            default:
                w_rve_bad = 1'b0;
        endcase
`else
        w_rve_bad = 1'b0;
`endif

        if (iwb_dat[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end
        w_ill = w_ill | w_rve_bad;
    end

    // Output registers: advance on sena, reset has priority.
    always_ff @(posedge sclk) begin
        if (srst) begin
            r_dpc  <= '0;
            r_dhrt <= 2'd0;
            r_dval <= 1'b0;
            r_dill <= 1'b0;
            r_drs1 <= 5'd0;
            r_drs2 <= 5'd0;
            r_drd  <= 5'd0;
            r_dopc <= 5'd0;
            r_dfn3 <= 3'd0;
            r_dfn7 <= 1'b0;
            r_dimm <= '0;
        end else if (sena) begin
            r_dpc  <= fpc[XLEN-1:2];
            r_dhrt <= w_hart;
            r_dval <= w_dval;
            r_dill <= w_ill;
            r_drs1 <= iwb_dat[19:15];
            r_drs2 <= iwb_dat[24:20];
            r_drd  <= w_rd;
            r_dopc <= w_opc;
            r_dfn3 <= iwb_dat[14:12];
            r_dfn7 <= iwb_dat[30];
            r_dimm <= w_imm;
        end
    end

    assign dpc  = r_dpc;
    assign dhrt = r_dhrt;
    assign dval = r_dval;
    assign dill = r_dill;
    assign drs1 = r_drs1;
    assign drs2 = r_drs2;
    assign drd  = r_drd;
    assign dopc = r_dopc;
    assign dfn3 = r_dfn3;
    assign dfn7 = r_dfn7;
    assign dimm = r_dimm;

endmodule

// File: tb/tb_t5_deco.sv
// Directed bench for t5_deco: warm-up, field decode, bubbles, kill mask,
// legality and the RV32E build option.
module tb_t5_deco;

    logic        sclk = 1'b0;
    logic        srst;
    logic        sena;
    logic [31:0] iwb_dat;
    logic        iwb_ack;
    logic [31:0] fpc;
    logic        xkill;
    logic [1:0]  xkhart;
    logic [29:0] dpc;
    logic [1:0]  dhrt;
    logic        dval;
    logic        dill;
    logic [4:0]  drs1;
    logic [4:0]  drs2;
    logic [4:0]  drd;
    logic [4:0]  dopc;
    logic [2:0]  dfn3;
    logic        dfn7;
    logic [31:0] dimm;

    int n_cmp = 0;
    int n_bad = 0;

    t5_deco #(.XLEN(32), .WARM(4)) dut (
        .sclk(sclk), .srst(srst), .sena(sena),
        .iwb_dat(iwb_dat), .iwb_ack(iwb_ack), .fpc(fpc),
        .xkill(xkill), .xkhart(xkhart),
        .dpc(dpc), .dhrt(dhrt), .dval(dval), .dill(dill),
        .drs1(drs1), .drs2(drs2), .drd(drd), .dopc(dopc),
        .dfn3(dfn3), .dfn7(dfn7), .dimm(dimm)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one clock edge, settle past the edge.
    task automatic step(input logic en, input logic ack, input logic [31:0] dat,
                        input logic [31:0] pc);
        sena    = en;
        iwb_ack = ack;
        iwb_dat = dat;
        fpc     = pc;
        @(posedge sclk);
        #1;
    endtask

    initial begin
        logic rve_exp;
`ifdef T5_RVE_EN
        rve_exp = 1'b1;
`else
        rve_exp = 1'b0;
`endif
        srst = 1'b1; sena = 1'b0; iwb_dat = 32'h0; iwb_ack = 1'b0;
        fpc = 32'h0; xkill = 1'b0; xkhart = 2'd0;
        @(posedge sclk); #1;
        // reset wins over sena
        step(1'b1, 1'b1, 32'h00500093, 32'h00000105);
        chk("rst_dval", {31'd0, dval}, 32'd0);
        chk("rst_dpc", {2'd0, dpc}, 32'd0);
        chk("rst_dimm", dimm, 32'd0);
        chk("rst_drd", {27'd0, drd}, 32'd0);
        chk("rst_dopc", {27'd0, dopc}, 32'd0);
        srst = 1'b0;

        // sena low: hold, no warm-up progress
        step(1'b0, 1'b1, 32'h00500093, 32'h00000010);
        chk("hold_dpc", {2'd0, dpc}, 32'd0);
        chk("hold_dopc", {27'd0, dopc}, 32'd0);

        // four warm-up bubbles
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 32'h00500093, 32'h00000010);
            chk("warm_dval", {31'd0, dval}, 32'd0);
        end
        step(1'b1, 1'b1, 32'h00500093, 32'h00000010);
        chk("addi_dval", {31'd0, dval}, 32'd1);
        chk("addi_drd", {27'd0, drd}, 32'd1);
        chk("addi_drs1", {27'd0, drs1}, 32'd0);
        chk("addi_dimm", dimm, 32'h00000005);
        chk("addi_dopc", {27'd0, dopc}, 32'h04);
        chk("addi_dill", {31'd0, dill}, 32'd0);
        chk("addi_dpc", {2'd0, dpc}, 32'h4);

        // BEQ offset -4
        step(1'b1, 1'b1, 32'hFE000EE3, 32'h00000103);
        chk("beq_dimm", dimm, 32'hFFFFFFFC);
        chk("beq_drd", {27'd0, drd}, 32'd0);
        chk("beq_dpc", {2'd0, dpc}, 32'h40);
        chk("beq_dhrt", {30'd0, dhrt}, 32'd3);
        chk("beq_dill", {31'd0, dill}, 32'd0);
        chk("beq_dval", {31'd0, dval}, 32'd1);

        // missing ack bubble, fields still decode
        step(1'b1, 1'b0, 32'h0020A423, 32'h00000200);
        chk("noack_dval", {31'd0, dval}, 32'd0);
        chk("sw_dimm", dimm, 32'h00000008);
        chk("sw_drd", {27'd0, drd}, 32'd0);
        chk("sw_drs1", {27'd0, drs1}, 32'd1);
        chk("sw_drs2", {27'd0, drs2}, 32'd2);
        chk("sw_dfn3", {29'd0, dfn3}, 32'd2);
        step(1'b1, 1'b1, 32'h12345037, 32'h00000204);
        chk("ack_dval", {31'd0, dval}, 32'd1);
        chk("lui_dimm", dimm, 32'h12345000);
        chk("lui_dopc", {27'd0, dopc}, 32'h0D);

        // kill hart 2 while stalled, then harts 0,1,2,3,2
        sena = 1'b0; xkill = 1'b1; xkhart = 2'd2;
        @(posedge sclk); #1;
        xkill = 1'b0;
        chk("kill_hold_dval", {31'd0, dval}, 32'd1);
        step(1'b1, 1'b1, 32'h00500093, 32'h00000300);
        chk("k_h0", {31'd0, dval}, 32'd1);
        step(1'b1, 1'b1, 32'h00500093, 32'h00000301);
        chk("k_h1", {31'd0, dval}, 32'd1);
        step(1'b1, 1'b1, 32'h00500093, 32'h00000302);
        chk("k_h2", {31'd0, dval}, 32'd0);
        step(1'b1, 1'b1, 32'h00500093, 32'h00000303);
        chk("k_h3", {31'd0, dval}, 32'd1);
        step(1'b1, 1'b1, 32'h00500093, 32'h00000306);
        chk("k_h2b", {31'd0, dval}, 32'd1);

        // set beats clear on the same hart
        xkill = 1'b1; xkhart = 2'd1;
        step(1'b1, 1'b1, 32'h00500093, 32'h00000301);
        xkill = 1'b0;
        chk("setclr_same_dval", {31'd0, dval}, 32'd1);
        step(1'b1, 1'b1, 32'h00500093, 32'h00000301);
        chk("setclr_next_dval", {31'd0, dval}, 32'd0);

        // legality
        step(1'b1, 1'b1, 32'h40000033, 32'h0);
        chk("sub_dill", {31'd0, dill}, 32'd0);
        chk("sub_dfn7", {31'd0, dfn7}, 32'd1);
        step(1'b1, 1'b1, 32'h02000033, 32'h0);
        chk("mul_dill", {31'd0, dill}, 32'd1);
        step(1'b1, 1'b1, 32'h00000000, 32'h0);
        chk("zero_dill", {31'd0, dill}, 32'd1);
        step(1'b1, 1'b1, 32'h00002063, 32'h0);
        chk("br_f3_2_dill", {31'd0, dill}, 32'd1);
        step(1'b1, 1'b1, 32'h01000813, 32'h0);
        chk("rve_dill", {31'd0, dill}, {31'd0, rve_exp});
        chk("rve_drd", {27'd0, drd}, 32'd16);

        // reset re-enters warm-up
        srst = 1'b1;
        step(1'b1, 1'b1, 32'h00500093, 32'h0);
        srst = 1'b0;
        step(1'b1, 1'b1, 32'h00500093, 32'h0);
        chk("rewarm_dval", {31'd0, dval}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
